// File: rtl/pulse_req_gate_if.sv
// Handshake and status bundle between a requester and the pulse_req_gate pacing stage.
interface pulse_req_gate_if;
   logic       req_valid;
   logic       req_ready;
   logic       pulse;
   logic       ack;
   logic       busy;
   logic       timeout;
   logic       stray_ack;
   logic [7:0] timeout_cnt;

   modport master (
      output req_valid, ack,
      input  req_ready, pulse, busy, timeout, stray_ack, timeout_cnt
   );

   modport slave (
      input  req_valid, ack,
      output req_ready, pulse, busy, timeout, stray_ack, timeout_cnt
   );
endinterface

// File: rtl/pulse_req_gate.sv
// Paces requests into a cross-domain pulse synchronizer: one pulse per request, then
// hold off until ack (or timeout) plus a guard gap so pulses can never merge downstream.
module pulse_req_gate #(
   parameter int MIN_GAP = 4,
   parameter int TIMEOUT = 1024
) (
   input logic              clk,
   input logic              rst,
   pulse_req_gate_if.slave  bus
);
   localparam int TW = $clog2(TIMEOUT);
   localparam int GW = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] G_LOAD = GW'(MIN_GAP);
   localparam logic [GW-1:0] G_ONE  = GW'(1);

   typedef enum logic [1:0] {IDLE, FIRE, WAIT_ACK, GAP} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic          to_hit;
   logic          timeout_r, stray_r;
   logic [7:0]    to_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         gap_cnt   <= '0;
         timeout_r <= 1'b0;
         stray_r   <= 1'b0;
         to_cnt    <= '0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         gap_cnt   <= gap_nxt;
         timeout_r <= to_hit;
         // ack only has meaning while waiting for it; anywhere else it is flagged
         stray_r   <= bus.ack && (state != WAIT_ACK);
         if (to_hit && (to_cnt != 8'hFF))
            to_cnt <= to_cnt + 8'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      gap_nxt   = gap_cnt;
      to_hit    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.req_valid)
               state_nxt = FIRE;
         end
         FIRE: begin
            timer_nxt = '0;
            state_nxt = WAIT_ACK;
         end
         WAIT_ACK: begin
            timer_nxt = timer + 1'b1;
            // ack on the final timer cycle still counts as a normal completion
            if (bus.ack || (timer == T_LAST)) begin
               to_hit    = !bus.ack;
               gap_nxt   = G_LOAD;
               state_nxt = (MIN_GAP == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            gap_nxt = gap_cnt - 1'b1;
            if (gap_cnt == G_ONE)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.req_ready   = (state == IDLE);
   assign bus.pulse       = (state == FIRE);
   assign bus.busy        = (state != IDLE);
   assign bus.timeout     = timeout_r;
   assign bus.stray_ack   = stray_r;
   assign bus.timeout_cnt = to_cnt;
endmodule
